// File: rtl/selection.sv
// Truncation selection for the GA engine: scores a latched population by
// popcount and emits the SEL_SIZE fittest individuals, best first.
module selection #(
  parameter int POP_SIZE = 50,
  parameter int IND_W    = 150,
  parameter int SEL_SIZE = 10,
  parameter int FIT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [POP_SIZE*IND_W-1:0] pop,
  output logic [SEL_SIZE*IND_W-1:0] sel_pop,
  output logic                      done
);

  localparam int IDX_W = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1;
  localparam int RND_W = (SEL_SIZE > 1) ? $clog2(SEL_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POP_SIZE - 1);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(SEL_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE, FIT, SCAN, DONE
  } state_e;

  state_e state_q, state_d;

  logic [POP_SIZE*IND_W-1:0] pop_q;
  logic [SEL_SIZE*IND_W-1:0] sel_q;
  logic [FIT_W-1:0]          fit_q [POP_SIZE];
  logic [POP_SIZE-1:0]       taken_q;
  logic [IDX_W-1:0]          idx_q;
  logic [IDX_W-1:0]          best_idx_q;
  logic [FIT_W-1:0]          best_fit_q;
  logic                      have_best_q;
  logic [RND_W-1:0]          rnd_q;
  logic                      done_q;

  function automatic logic [FIT_W-1:0] popcnt(input logic [IND_W-1:0] v);
    logic [FIT_W-1:0] c;
    c = '0;
    for (int i = 0; i < IND_W; i++)
      c = c + {{(FIT_W-1){1'b0}}, v[i]};
    return c;
  endfunction

  logic             accept;
  logic             last_idx;
  logic             last_rnd;
  logic [IND_W-1:0] cur_ind;
  logic [FIT_W-1:0] cur_pc;
  logic [FIT_W-1:0] cur_fit;
  logic             cand;
  logic [IDX_W-1:0] win_idx;

  assign accept   = start && (state_q == IDLE || state_q == DONE);
  assign last_idx = (idx_q == LAST_IDX);
  assign last_rnd = (rnd_q == LAST_RND);
  assign cur_ind  = pop_q[idx_q*IND_W +: IND_W];
  assign cur_pc   = popcnt(cur_ind);
  assign cur_fit  = fit_q[idx_q];
  // Strict compare keeps the lowest index on ties.
  assign cand     = !taken_q[idx_q] &&
                    (!have_best_q || cur_fit > best_fit_q);
  assign win_idx  = cand ? idx_q : best_idx_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = FIT;
      FIT:        if (last_idx) state_d = SCAN;
      SCAN:       if (last_idx && last_rnd) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pop_q       <= '0;
      sel_q       <= '0;
      taken_q     <= '0;
      idx_q       <= '0;
      best_idx_q  <= '0;
      best_fit_q  <= '0;
      have_best_q <= 1'b0;
      rnd_q       <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < POP_SIZE; i++)
        fit_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pop_q       <= pop;
        sel_q       <= '0;
        taken_q     <= '0;
        idx_q       <= '0;
        best_idx_q  <= '0;
        best_fit_q  <= '0;
        have_best_q <= 1'b0;
        rnd_q       <= '0;
        done_q      <= 1'b0;
      end else if (state_q == FIT) begin
        fit_q[idx_q] <= cur_pc;
        idx_q        <= last_idx ? '0 : idx_q + 1'b1;
      end else if (state_q == SCAN) begin
        idx_q <= last_idx ? '0 : idx_q + 1'b1;
        if (last_idx) begin
          sel_q[rnd_q*IND_W +: IND_W] <= pop_q[win_idx*IND_W +: IND_W];
          taken_q[win_idx] <= 1'b1;
          have_best_q      <= 1'b0;
          rnd_q            <= last_rnd ? '0 : rnd_q + 1'b1;
          if (last_rnd)
            done_q <= 1'b1;
        end else if (cand) begin
          have_best_q <= 1'b1;
          best_idx_q  <= idx_q;
          best_fit_q  <= cur_fit;
        end
      end
    end
  end

  assign sel_pop = sel_q;
  assign done    = done_q;

endmodule

// File: tb/tb_selection.sv
// Scoreboard bench for selection: stimulus pushes model results,
// a negedge monitor pops and compares when done rises.
module tb_selection;
  localparam int POP = 50;
  localparam int W   = 150;
  localparam int SEL = 10;
  localparam int PW  = POP * W;
  localparam int SW  = SEL * W;
  localparam int LAT = POP * (SEL + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] pop_r = '0;
  logic [SW-1:0] sel_pop;
  logic          done;

  int vectors = 0;
  int miscompares = 0;

  logic [SW-1:0] exp_q[$];
  time           acc_q[$];
  logic          prev_done = 1'b0;

  selection dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .pop     (pop_r),
    .sel_pop (sel_pop),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [SW-1:0] model(input logic [PW-1:0] p);
    int            keys[$];
    logic [W-1:0]  ind;
    logic [SW-1:0] res;
    int            idx;
    res = '0;
    for (int i = 0; i < POP; i++) begin
      ind = p[i*W +: W];
      keys.push_back($countones(ind) * 1000 + (999 - i));
    end
    keys.rsort();
    for (int r = 0; r < SEL; r++) begin
      idx = 999 - (keys[r] % 1000);
      res[r*W +: W] = p[idx*W +: W];
    end
    return res;
  endfunction

  always @(negedge clk) begin
    logic [SW-1:0] e;
    time           t;
    if (done && !prev_done) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: done=1 with empty scoreboard");
      end else begin
        e = exp_q.pop_front();
        t = acc_q.pop_front();
        chk("latency", W'(($time - t - 5) / 10), W'(LAT));
        for (int r = 0; r < SEL; r++)
          chk($sformatf("slot%0d", r), sel_pop[r*W +: W], e[r*W +: W]);
      end
    end
    prev_done = done;
  end

  task automatic start_run(input logic [PW-1:0] p, input int hold);
    @(negedge clk);
    pop_r = p;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(p));
    acc_q.push_back($time);
    #1;
    chk("done_clr", W'(done), W'(0));
    chk("sel_clr", W'(sel_pop != '0), W'(0));
    repeat (hold - 1) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < LAT + 50 && !done; i++) @(negedge clk);
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: done=%0b expected 1", done);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic logic [PW-1:0] rand_pop(input bit few);
    logic [PW-1:0] p;
    int dens;
    p = '0;
    for (int i = 0; i < POP; i++) begin
      if (few) begin
        for (int k = 0; k < int'($urandom_range(3)); k++)
          p[i*W + int'($urandom_range(W-1))] = 1'b1;
      end else begin
        dens = $urandom_range(100);
        for (int b = 0; b < W; b++)
          p[i*W + b] = ($urandom_range(99) < dens);
      end
    end
    return p;
  endfunction

  initial begin
    logic [PW-1:0] p;
    logic [SW-1:0] e6;

    repeat (3) @(negedge clk);
    chk("rst_done", W'(done), W'(0));
    chk("rst_sel", W'(sel_pop != '0), W'(0));
    rst_n = 1'b1;

    // 1: single non-zero individual, start held 5 cycles
    p = '0;
    p[23:0] = '1;
    start_run(p, 5);
    wait_done();

    // 2: individual i has i ones
    p = '0;
    for (int i = 0; i < POP; i++)
      for (int b = 0; b < i; b++) p[i*W + b] = 1'b1;
    start_run(p, 1);
    wait_done();

    // 3: all fitness 5, distinct patterns
    p = '0;
    for (int i = 0; i < POP; i++)
      for (int b = 0; b < 5; b++) p[i*W + i + b] = 1'b1;
    start_run(p, 1);
    wait_done();

    // 4: one all-ones individual, others 3 ones
    p = '0;
    for (int i = 0; i < POP; i++) p[i*W +: 3] = 3'b111;
    p[37*W +: W] = '1;
    start_run(p, 1);
    wait_done();

    // 5: reset in the middle of a run
    p = rand_pop(1'b0);
    start_run(p, 1);
    repeat (199) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_done", W'(done), W'(0));
    chk("abort_sel", W'(sel_pop != '0), W'(0));
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_run(rand_pop(1'b0), 1);
    wait_done();

    // 6: start pulse and pop change mid-run are ignored
    p = rand_pop(1'b0);
    e6 = model(p);
    start_run(p, 1);
    repeat (300) @(negedge clk);
    pop_r = rand_pop(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pop_r = rand_pop(1'b1);
    wait_done();
    repeat (5) @(negedge clk);
    chk("hold_done", W'(done), W'(1));
    for (int r = 0; r < SEL; r++)
      chk($sformatf("hold_slot%0d", r), sel_pop[r*W +: W], e6[r*W +: W]);
    start_run(rand_pop(1'b0), 1);
    wait_done();

    // random populations, dense and tie-heavy
    for (int n = 0; n < 6; n++) begin
      start_run(rand_pop(n[0]), 1 + (n % 3));
      wait_done();
    end

    chk("sb_empty", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
